mem_io_responder: RTL and testbench

//   Memory-side responder for the dispatcher's byte-wide memory port: one byte access per cycle.

---
 rtl/mem_io_responder_pkg.sv | 40 ++++
 rtl/mem_io_responder_byte_fifo.sv | 49 ++++
 rtl/mem_io_responder.sv | 158 +++++++++++++++
 tb/tb_mem_io_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, access decode and status packing for the memory/IO responder.
package mem_io_responder_pkg;

  localparam int MEM_WIDTH = 8;

  localparam logic [1:0] IO_REGION_MARK = 2'b11;
  localparam logic [2:0] IO_DATA_OFFSET = 3'd0;
  localparam logic [2:0] IO_STAT_OFFSET = 3'd4;

  localparam logic READ_SIGNAL  = 1'b0;
  localparam logic WRITE_SIGNAL = 1'b1;

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_IO_DATA,
    ACC_IO_STAT,
    ACC_IO_NONE
  } access_e;

  function automatic access_e decode_access(input logic [1:0] region, input logic [2:0] offset);
    access_e acc;
    acc = ACC_RAM;
    if (region == IO_REGION_MARK) begin
      if (offset == IO_DATA_OFFSET)
        acc = ACC_IO_DATA;
      else if (offset == IO_STAT_OFFSET)
        acc = ACC_IO_STAT;
      else
        acc = ACC_IO_NONE;
    end
    return acc;
  endfunction

  function automatic logic [MEM_WIDTH-1:0] status_byte(input logic tx_overflow,
                                                       input logic rx_nonempty,
                                                       input logic tx_full);
    return {5'b0, tx_overflow, rx_nonempty, tx_full};
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO used for both the TX and RX paths; callers only assert push/pop when legal.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [MEM_WIDTH-1:0]    push_data,
  output logic [MEM_WIDTH-1:0]    head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [MEM_WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      storage[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = storage[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: 128 KiB RAM plus a TX/RX FIFO IO window at addr[17:16]==2'b11.
// Optional MEM_IO_SIM_CONSOLE_EN echoes TX pushes to the console and ends sim on 0xFF to status.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH      = 8,
  parameter int RX_DEPTH      = 8
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [31:0] in_mem_addr,
  input  logic        in_mem_wr,
  input  logic [7:0]  in_mem_data,
  output logic [7:0]  out_mem_data,
  output logic        out_io_full,
  output logic [7:0]  out_tx_data,
  output logic        out_tx_valid,
  input  logic        in_tx_ready,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_valid,
  output logic        out_rx_ready
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  access_e                  acc;
  logic                     is_write;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     ram_we;

  logic [MEM_WIDTH-1:0] ram [2**RAM_ADDR_BITS];
  logic [MEM_WIDTH-1:0] ram_q;
  logic [MEM_WIDTH-1:0] io_next;
  logic [MEM_WIDTH-1:0] io_q;
  logic                 sel_ram_q;

  logic                 tx_push;
  logic                 tx_push_req;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic [TXCW-1:0]      tx_count;
  logic [TXCW-1:0]      tx_count_next;
  logic                 tx_overflow;
  logic                 io_full_q;

  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic [MEM_WIDTH-1:0] rx_head;
  logic [RXCW-1:0]      unused_rx_count;
  logic                 unused_addr_hi;

  assign acc            = decode_access(in_mem_addr[17:16], in_mem_addr[2:0]);
  assign is_write       = (in_mem_wr == WRITE_SIGNAL);
  assign ram_addr       = in_mem_addr[RAM_ADDR_BITS-1:0];
  assign unused_addr_hi = ^in_mem_addr[31:18];

  // A write issued while reset is asserted is dropped rather than landing in RAM.
  assign ram_we = (acc == ACC_RAM) && is_write && in_rst_n;

  // Host drains TX head when ready; a push into a full FIFO is still taken if the head leaves this cycle.
  assign tx_pop      = !tx_empty && in_tx_ready;
  assign tx_push_req = (acc == ACC_IO_DATA) && is_write;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  assign rx_pop  = (acc == ACC_IO_DATA) && !is_write && !rx_empty;
  assign rx_push = in_rx_valid && !rx_full;

  assign tx_count_next = tx_count + TXCW'(tx_push) - TXCW'(tx_pop);

  byte_fifo #(.DEPTH(TX_DEPTH)) tx_fifo (
    .clk       (in_clk),
    .rst_n     (in_rst_n),
    .push      (tx_push),
    .pop       (tx_pop),
    .push_data (in_mem_data),
    .head      (out_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) rx_fifo (
    .clk       (in_clk),
    .rst_n     (in_rst_n),
    .push      (rx_push),
    .pop       (rx_pop),
    .push_data (in_rx_data),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (unused_rx_count)
  );

  // Read-first single-port RAM; no reset so it maps onto block memory.
  always_ff @(posedge in_clk) begin
    if (ram_we)
      ram[ram_addr] <= in_mem_data;
    ram_q <= ram[ram_addr];
  end

  always_comb begin
    io_next = '0;
    case (acc)
      ACC_IO_DATA: begin
        if (!is_write && !rx_empty)
          io_next = rx_head;
      end
      ACC_IO_STAT: io_next = status_byte(tx_overflow, !rx_empty, tx_full);
      default:     io_next = '0;
    endcase
  end

  // Overflow is sticky until a status write; io_full tracks the post-edge TX occupancy.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sel_ram_q   <= 1'b0;
      io_q        <= '0;
      tx_overflow <= 1'b0;
      io_full_q   <= 1'b0;
    end else begin
      sel_ram_q <= (acc == ACC_RAM);
      io_q      <= io_next;
      io_full_q <= (tx_count_next >= TXCW'(TX_DEPTH - 1));
      if ((acc == ACC_IO_STAT) && is_write)
        tx_overflow <= 1'b0;
      else if (tx_push_req && !tx_push)
        tx_overflow <= 1'b1;
    end
  end

  assign out_mem_data = sel_ram_q ? ram_q : io_q;
  assign out_io_full  = io_full_q;
  assign out_tx_valid = !tx_empty;
  assign out_rx_ready = !rx_full;

`ifdef MEM_IO_SIM_CONSOLE_EN
  logic finish_pending;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      finish_pending <= 1'b0;
    end else begin
      if (tx_push)
        $write("%c", in_mem_data);
      if ((acc == ACC_IO_STAT) && is_write && (in_mem_data == 8'hFF))
        finish_pending <= 1'b1;
      if (finish_pending)
        $finish;
    end
  end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: queue/array reference model plus directed literal checks.
module tb_mem_io_responder;

  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        wr;
  logic [7:0]  data;
  logic [7:0]  out_mem_data;
  logic        out_io_full;
  logic [7:0]  out_tx_data;
  logic        out_tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        out_rx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_m [int];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  logic       ovf;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       pop_tx;
  logic       push_rx;
  logic       tx_accept;
  int         idx;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_mem_addr  (addr),
    .in_mem_wr    (wr),
    .in_mem_data  (data),
    .out_mem_data (out_mem_data),
    .out_io_full  (out_io_full),
    .out_tx_data  (out_tx_data),
    .out_tx_valid (out_tx_valid),
    .in_tx_ready  (tx_ready),
    .in_rx_data   (rx_data),
    .in_rx_valid  (rx_valid),
    .out_rx_ready (out_rx_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request at a falling edge and return at the next falling edge, after it was served.
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [7:0] d);
    addr = a;
    wr   = w;
    data = d;
    @(negedge clk);
  endtask

  // Reference model: advance on every rising edge, then compare all meaningful outputs.
  always @(posedge clk) begin
    exp_valid = 1'b0;
    tx_accept = 1'b0;
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      ovf       = 1'b0;
      exp_data  = 8'h00;
      exp_valid = 1'b1;
    end else begin
      pop_tx  = tx_ready && (txq.size() > 0);
      push_rx = rx_valid && (rxq.size() < RXD);
      if (addr[17:16] != 2'b11) begin
        idx = int'(addr[16:0]);
        if (wr)
          ram_m[idx] = data;
        else if (ram_m.exists(idx)) begin
          exp_data  = ram_m[idx];
          exp_valid = 1'b1;
        end
      end else begin
        case (addr[2:0])
          3'd0: begin
            if (wr) begin
              if ((txq.size() < TXD) || pop_tx)
                tx_accept = 1'b1;
              else
                ovf = 1'b1;
            end else begin
              exp_valid = 1'b1;
              exp_data  = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
            end
          end
          3'd4: begin
            if (wr)
              ovf = 1'b0;
            else begin
              exp_valid = 1'b1;
              exp_data  = {5'b0, ovf, rxq.size() > 0, txq.size() == TXD};
            end
          end
          default: begin
            if (!wr) begin
              exp_valid = 1'b1;
              exp_data  = 8'h00;
            end
          end
        endcase
      end
      if (pop_tx)
        void'(txq.pop_front());
      if (tx_accept)
        txq.push_back(data);
      if (push_rx)
        rxq.push_back(rx_data);
    end
    #1;
    checkOutput("tx_valid", out_tx_valid, txq.size() > 0);
    if (txq.size() > 0)
      checkOutput("tx_data", out_tx_data, txq[0]);
    checkOutput("rx_ready", out_rx_ready, rxq.size() < RXD);
    checkOutput("io_full", out_io_full, txq.size() >= TXD - 1);
    if (exp_valid)
      checkOutput("mem_data", out_mem_data, exp_data);
  end

  initial begin
    logic [31:0] r;
    int          k;
    logic [2:0]  off;

    rst_n    = 1'b0;
    addr     = 32'h0;
    wr       = 1'b0;
    data     = 8'h00;
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_data", out_mem_data, 8'h00);
    checkOutput("rst_io_full", out_io_full, 1'b0);
    checkOutput("rst_tx_valid", out_tx_valid, 1'b0);
    checkOutput("rst_rx_ready", out_rx_ready, 1'b1);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("rst_no_rx_entry", out_mem_data, 8'h00);

    applyStimulus(32'h0000_0123, 1'b1, 8'hA5);
    applyStimulus(32'h0000_0123, 1'b0, 8'h00);
    checkOutput("ram_wr_rd", out_mem_data, 8'hA5);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(32'h0003_0000, 1'b1, 8'h10 + 8'(i));
      if (i == 5)
        checkOutput("io_full_at_6", out_io_full, 1'b0);
    end
    checkOutput("io_full_at_7", out_io_full, 1'b1);
    applyStimulus(32'h0003_0000, 1'b1, 8'h17);
    checkOutput("tx_full_rx_ready", out_rx_ready, 1'b1);
    applyStimulus(32'h0003_0000, 1'b1, 8'h18);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("status_overflow", out_mem_data, 8'h05);
    checkOutput("tx_head_first", out_tx_data, 8'h10);

    applyStimulus(32'h0003_0004, 1'b1, 8'h00);
    tx_ready = 1'b1;
    repeat (TXD) applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("tx_drained", out_tx_valid, 1'b0);
    tx_ready = 1'b0;

    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    applyStimulus(32'h0003_0000, 1'b1, 8'h42);
    applyStimulus(32'h0003_0000, 1'b1, 8'h43);
    checkOutput("tx_order_0", out_tx_data, 8'h41);
    tx_ready = 1'b1;
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("tx_order_1", out_tx_data, 8'h42);
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("tx_order_2", out_tx_data, 8'h43);
    applyStimulus(32'h0, 1'b0, 8'h00);
    checkOutput("tx_valid_falls", out_tx_valid, 1'b0);
    tx_ready = 1'b0;

    rx_valid = 1'b1;
    rx_data  = 8'h31;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    checkOutput("rx_empty_pop", out_mem_data, 8'h00);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("status_rx_ne", out_mem_data, 8'h02);
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    checkOutput("rx_pop_31", out_mem_data, 8'h31);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("status_rx_empty", out_mem_data, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      if (n == 1500 || n == 1501)
        rst_n = 1'b0;
      else
        rst_n = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        addr = {r[31:18], 2'($urandom_range(0, 2)), 12'h000, 4'($urandom_range(0, 15))};
      end else begin
        k = $urandom_range(0, 9);
        if (k < 6)
          off = 3'd0;
        else if (k < 9)
          off = 3'd4;
        else
          off = 3'($urandom_range(0, 7));
        addr = {r[31:18], 2'b11, r[15:3], off};
      end
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      applyStimulus(addr, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    rst_n = 1'b1;
    applyStimulus(32'h0, 1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
